grpci2_axi_lite_mst: RTL and testbench
======================================

GRPCI2_AXI_LITE_MST -- requirements
Module: grpci2_axi_lite_mst

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 15, giving the maximum RETRY/SPLIT re-issues before an SLVERR is returned.
REQ-002 SHALL have parameter HPROT, default 4'b0011, driven constant on ahb_m_hprot.
REQ-003 SHALL have one clock and a synchronous, active-high reset: aclk and areset.
REQ-004 Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_awvalid/s_awready  in/out  1  write address handshake
- s_awaddr  in  32  write address
- s_wvalid/s_wready  in/out  1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid/s_bready  out/in  1  write response handshake
- s_bresp  out  2  write response
- s_arvalid/s_arready  in/out  1  read address handshake
- s_araddr  in  32  read address
- s_rvalid/s_rready  out/in  1  read data handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- ahb_m_hsel  out  1  slave select
- ahb_m_haddr  out  32  address
- ahb_m_hwrite  out  1  direction
- ahb_m_htrans  out  2  transfer type
- ahb_m_hsize  out  3  transfer size
- ahb_m_hburst  out  3  burst type
- ahb_m_hprot  out  4  protection
- ahb_m_hwdata  out  32  write data
- ahb_m_hready  in  1  slave ready
- ahb_m_hresp  in  2  slave response
- ahb_m_hrdata  in  32  read data

Function
REQ-005 SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> IDLE, with one single AHB transfer in flight at a time.
REQ-006 IDLE: s_awready and s_wready SHALL be asserted together, and only when both s_awvalid and s_wvalid are high; s_arready SHALL be asserted when s_arvalid is high; at most one channel is accepted per cycle.
REQ-007 Simultaneous read and write pending in IDLE SHALL be granted alternately; write wins first after reset.
REQ-008 Accepted address, data and strobes SHALL be registered.
REQ-009 The next state after acceptance SHALL be ADDR, or RESP directly if no AHB transfer is needed (see REQ-015/REQ-016).
REQ-010 ADDR: SHALL drive hsel=1, htrans=NONSEQ (2'b10), hburst=SINGLE (3'b000), and hold haddr/hwrite/hsize; the FSM SHALL stay in ADDR while hready=0 and move to DATA on hready=1.
REQ-011 DATA: SHALL drive htrans=IDLE and hsel=0, and drive hwdata with the registered wdata (all 32 bits, lanes unshifted); the FSM SHALL wait for hready=1, then sample hresp.
REQ-012 hresp handling in DATA on hready=1:
- OKAY: capture hrdata (reads) and set resp=OKAY (2'b00).
- ERROR: set resp=SLVERR (2'b10).
- RETRY/SPLIT, retry count < RETRY_MAX: increment count and return to ADDR with the identical request.
- RETRY/SPLIT, retry count = RETRY_MAX: set resp=SLVERR.
REQ-013 A first-cycle non-OKAY response (hready=0, hresp!=OKAY) SHALL see htrans=IDLE, which is already guaranteed in DATA.
REQ-014 RESP: SHALL hold s_bvalid (writes) or s_rvalid (reads) with resp/rdata stable until the ready signal, then return to IDLE with the retry count cleared; a write SHALL never raise s_rvalid and vice versa.
REQ-015 Write strobe mapping, giving hsize and haddr={awaddr[31:2],off}:
- 1111: word, off=00.
- 0011: half, off=00.
- 1100: half, off=10.
- 0001/0010/0100/1000: byte, off=00/01/10/11.
REQ-016 Other strobe cases SHALL skip the AHB transfer and go straight to RESP:
- 0000: resp=OKAY.
- Any other pattern: resp=SLVERR.
REQ-017 Reads SHALL always be word size, haddr={araddr[31:2],2'b00}, with s_rdata equal to the full hrdata word.
REQ-018 Latency with hready constantly 1: acceptance in cycle N, NONSEQ in N+1, data phase in N+2, response valid in N+3.
REQ-019 Outside ADDR: hsel=0 and htrans=IDLE; haddr, hwrite, hsize and hwdata MAY hold their last values.

Reset
REQ-020 On areset=1 at a clock edge the following SHALL apply from the next cycle:
- FSM=IDLE.
- All s_*ready and s_*valid outputs = 0.
- bresp/rresp=00, rdata=0.
- hsel=0, htrans=IDLE, haddr=0, hwrite=0, hsize=010, hwdata=0.
- Retry count=0, priority=write.
REQ-021 Reset mid-transfer SHALL abandon the request with no AXI response issued and no further AHB activity.

Verification
REQ-022 Write 0x1234_5678 to 0x0000_0104 with strb=1111, hready=1 -> one NONSEQ, haddr=0x104, hsize=010, hwrite=1; bvalid in cycle N+3, bresp=00.
REQ-023 Write with strb=0100 to 0x200 -> haddr=0x202, hsize=000; strb=0101 -> no AHB transfer, bresp=10.
REQ-024 Read 0x0000_0010 with hready low for 3 cycles in ADDR, hrdata=0xCAFE_F00D -> rvalid once, rdata=0xCAFE_F00D, rresp=00; NONSEQ held during the stall.
REQ-025 Slave returns RETRY 2 times then OKAY -> exactly 3 NONSEQ issued, bresp=00; with RETRY_MAX=2 and 3 RETRYs -> bresp=10 after the 3rd.
REQ-026 AR and AW/W valid in the same cycle, twice in succession -> the write is served first, then the read, then the write.
REQ-027 Assert areset while in DATA -> htrans=IDLE and bvalid=0 the next cycle, FSM in IDLE, and a subsequent write completes normally.

Source files
------------

// File: rtl/grpci2_axi_lite_mst_if.sv
// Signal bundle for the grpci2 AXI4-Lite to AHB bridge: AXI-Lite slave channels plus AHB master bus.
// The master modport is the bridge side; the slave modport is the environment (AXI requester and AHB slave).
interface grpci2_axi_lite_mst_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        ahb_m_hsel;
  logic [31:0] ahb_m_haddr;
  logic        ahb_m_hwrite;
  logic [1:0]  ahb_m_htrans;
  logic [2:0]  ahb_m_hsize;
  logic [2:0]  ahb_m_hburst;
  logic [3:0]  ahb_m_hprot;
  logic [31:0] ahb_m_hwdata;
  logic        ahb_m_hready;
  logic [1:0]  ahb_m_hresp;
  logic [31:0] ahb_m_hrdata;

  modport master (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
           ahb_m_hready, ahb_m_hresp, ahb_m_hrdata,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
           ahb_m_hsel, ahb_m_haddr, ahb_m_hwrite, ahb_m_htrans, ahb_m_hsize,
           ahb_m_hburst, ahb_m_hprot, ahb_m_hwdata
  );

  modport slave (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
           ahb_m_hready, ahb_m_hresp, ahb_m_hrdata,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
           ahb_m_hsel, ahb_m_haddr, ahb_m_hwrite, ahb_m_htrans, ahb_m_hsize,
           ahb_m_hburst, ahb_m_hprot, ahb_m_hwdata
  );
endinterface

// File: rtl/grpci2_axi_lite_mst.sv
// AXI4-Lite slave to AHB master bridge: one single AHB transfer in flight, write/read arbitration
// alternating under contention, RETRY/SPLIT re-issue up to RETRY_MAX times before SLVERR.
module grpci2_axi_lite_mst #(
  parameter int unsigned RETRY_MAX = 15,
  parameter logic [3:0]  HPROT     = 4'b0011
) (
  input  logic                  aclk,
  input  logic                  areset,
  grpci2_axi_lite_mst_if.master bus
);
  localparam int unsigned   CW            = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [CW-1:0] RMAX          = CW'(RETRY_MAX);
  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]    HRESP_OKAY    = 2'b00;
  localparam logic [1:0]    RESP_OKAY     = 2'b00;
  localparam logic [1:0]    RESP_SLVERR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        state, state_n;
  logic          wr_q;
  logic          prio_rd;
  logic [31:0]   haddr_q;
  logic [31:0]   hwdata_q;
  logic [31:0]   rdata_q;
  logic [2:0]    hsize_q;
  logic [1:0]    resp_q;
  logic [CW-1:0] retry_cnt;

  logic [2:0]    dec_size;
  logic [1:0]    dec_off;
  logic          dec_skip;
  logic          dec_err;
  logic          wr_req;
  logic          take_wr;
  logic          take_rd;
  logic          retry_again;
  logic          rsp_ack;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};

  // Strobe pattern selects transfer size and lane offset; unsupported patterns never reach AHB.
  always_comb begin
    dec_size = 3'b010;
    dec_off  = 2'b00;
    dec_skip = 1'b0;
    dec_err  = 1'b0;
    case (bus.s_wstrb)
      4'b1111: ;
      4'b0011: dec_size = 3'b001;
      4'b1100: begin dec_size = 3'b001; dec_off = 2'b10; end
      4'b0001: dec_size = 3'b000;
      4'b0010: begin dec_size = 3'b000; dec_off = 2'b01; end
      4'b0100: begin dec_size = 3'b000; dec_off = 2'b10; end
      4'b1000: begin dec_size = 3'b000; dec_off = 2'b11; end
      4'b0000: dec_skip = 1'b1;
      default: begin dec_skip = 1'b1; dec_err = 1'b1; end
    endcase
  end

  assign wr_req      = bus.s_awvalid && bus.s_wvalid;
  assign retry_again = bus.ahb_m_hresp[1] && (retry_cnt != RMAX);
  assign rsp_ack     = wr_q ? bus.s_bready : bus.s_rready;

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    take_wr = 1'b0;
    take_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_req && !(bus.s_arvalid && prio_rd)) take_wr = 1'b1;
        else if (bus.s_arvalid)                    take_rd = 1'b1;
        if (take_wr)      state_n = dec_skip ? S_RESP : S_ADDR;
        else if (take_rd) state_n = S_ADDR;
      end
      S_ADDR:  if (bus.ahb_m_hready) state_n = S_DATA;
      S_DATA:  if (bus.ahb_m_hready) state_n = retry_again ? S_ADDR : S_RESP;
      S_RESP:  if (rsp_ack) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q      <= 1'b0;
      prio_rd   <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      rdata_q   <= '0;
      hsize_q   <= 3'b010;
      resp_q    <= RESP_OKAY;
      retry_cnt <= '0;
    end else begin
      if (take_wr) begin
        wr_q     <= 1'b1;
        prio_rd  <= 1'b1;
        haddr_q  <= {bus.s_awaddr[31:2], dec_off};
        hsize_q  <= dec_size;
        hwdata_q <= bus.s_wdata;
        resp_q   <= dec_err ? RESP_SLVERR : RESP_OKAY;
      end else if (take_rd) begin
        wr_q    <= 1'b0;
        prio_rd <= 1'b0;
        haddr_q <= {bus.s_araddr[31:2], 2'b00};
        hsize_q <= 3'b010;
        resp_q  <= RESP_OKAY;
      end
      if (state == S_DATA && bus.ahb_m_hready) begin
        if (bus.ahb_m_hresp == HRESP_OKAY) begin
          resp_q <= RESP_OKAY;
          if (!wr_q) rdata_q <= bus.ahb_m_hrdata;
        end else if (retry_again) begin
          retry_cnt <= retry_cnt + CW'(1);
        end else begin
          resp_q <= RESP_SLVERR;
        end
      end
      if (state == S_RESP && rsp_ack) retry_cnt <= '0;
    end
  end

  assign bus.s_awready    = take_wr;
  assign bus.s_wready     = take_wr;
  assign bus.s_arready    = take_rd;
  assign bus.s_bvalid     = (state == S_RESP) && wr_q;
  assign bus.s_rvalid     = (state == S_RESP) && !wr_q;
  assign bus.s_bresp      = resp_q;
  assign bus.s_rresp      = resp_q;
  assign bus.s_rdata      = rdata_q;
  assign bus.ahb_m_hsel   = (state == S_ADDR);
  assign bus.ahb_m_htrans = (state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.ahb_m_haddr  = haddr_q;
  assign bus.ahb_m_hwrite = wr_q;
  assign bus.ahb_m_hsize  = hsize_q;
  assign bus.ahb_m_hburst = 3'b000;
  assign bus.ahb_m_hprot  = HPROT;
  assign bus.ahb_m_hwdata = hwdata_q;
endmodule

// File: tb/tb_grpci2_axi_lite_mst.sv
// Directed bench for grpci2_axi_lite_mst: strobe mapping, latency, stalls, retries, arbitration, reset.
module tb_grpci2_axi_lite_mst;
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  grpci2_axi_lite_mst_if bus ();
  grpci2_axi_lite_mst_if bus2 ();

  grpci2_axi_lite_mst dut (.aclk(aclk), .areset(areset), .bus(bus));
  grpci2_axi_lite_mst #(.RETRY_MAX(2)) dut_r2 (.aclk(aclk), .areset(areset), .bus(bus2));

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // AHB slave model for bus: address-phase stall and a number of RETRY answers per transaction
  int          cfg_stall     = 0;
  int          cfg_retry     = 0;
  logic [31:0] cfg_rdata     = '0;
  int          addr_wait     = 0;
  int          retries_given = 0;
  logic        dphase        = 1'b0;
  int          ns_cnt        = 0;
  int          b_cnt         = 0;
  int          r_cnt         = 0;

  assign bus.ahb_m_hready = (bus.ahb_m_htrans == 2'b10) ? (addr_wait >= cfg_stall) : 1'b1;
  assign bus.ahb_m_hresp  = (dphase && retries_given < cfg_retry) ? 2'b10 : 2'b00;
  assign bus.ahb_m_hrdata = cfg_rdata;

  always @(posedge aclk) begin
    if (bus.ahb_m_htrans != 2'b10) addr_wait <= 0;
    else if (!bus.ahb_m_hready)    addr_wait <= addr_wait + 1;
    dphase <= (bus.ahb_m_htrans == 2'b10) && bus.ahb_m_hready;
    if (bus.s_bvalid || bus.s_rvalid)          retries_given <= 0;
    else if (dphase && bus.ahb_m_hresp[1])     retries_given <= retries_given + 1;
    if (bus.ahb_m_htrans == 2'b10 && bus.ahb_m_hready) ns_cnt <= ns_cnt + 1;
    if (bus.s_bvalid && bus.s_bready) b_cnt <= b_cnt + 1;
    if (bus.s_rvalid && bus.s_rready) r_cnt <= r_cnt + 1;
  end

  // bus2 slave always answers RETRY in the data phase
  logic dphase2 = 1'b0;
  int   ns2     = 0;
  assign bus2.ahb_m_hready = 1'b1;
  assign bus2.ahb_m_hresp  = dphase2 ? 2'b10 : 2'b00;
  assign bus2.ahb_m_hrdata = '0;
  always @(posedge aclk) begin
    dphase2 <= (bus2.ahb_m_htrans == 2'b10);
    if (bus2.ahb_m_htrans == 2'b10) ns2 <= ns2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int acc);
    bit done = 0;
    acc = -1;
    @(negedge aclk);
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = s;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (bus.s_awready && bus.s_wready) begin done = 1; acc = cyc; end
      @(negedge aclk);
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    if (!done) check("aw_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, output int acc);
    bit done = 0;
    acc = -1;
    @(negedge aclk);
    bus.s_araddr = a; bus.s_arvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (bus.s_arready) begin done = 1; acc = cyc; end
      @(negedge aclk);
    end
    bus.s_arvalid = 1'b0;
    if (!done) check("ar_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(input bit is_wr, input int hold, output logic [1:0] rsp,
                           output logic [31:0] rd, output int at);
    bit done = 0;
    rsp = 2'b11; rd = '0; at = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (is_wr ? bus.s_bvalid : bus.s_rvalid) begin
        done = 1; at = cyc;
        rsp = is_wr ? bus.s_bresp : bus.s_rresp;
        rd  = bus.s_rdata;
        check(is_wr ? "rvalid_on_write" : "bvalid_on_read",
              32'(is_wr ? bus.s_rvalid : bus.s_bvalid), 32'd0);
        for (int h = 0; h < hold; h++) begin
          @(negedge aclk);
          check("valid_held", 32'(is_wr ? bus.s_bvalid : bus.s_rvalid), 32'd1);
          check("payload_held", is_wr ? 32'(bus.s_bresp) : bus.s_rdata, is_wr ? 32'(rsp) : rd);
        end
        if (is_wr) bus.s_bready = 1'b1; else bus.s_rready = 1'b1;
        @(negedge aclk);
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        check("valid_drop", 32'(bus.s_bvalid | bus.s_rvalid), 32'd0);
      end else begin
        @(negedge aclk);
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    bit          skip;
    logic [1:0]  resp;
  } wvec_t;

  wvec_t wv[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int          acc, at, w1, w2, rr, ns0, b0, r0;
    logic [1:0]  rsp;
    logic [31:0] rd, d;

    wv[0] = '{32'h104, 4'b1111, 32'h104, 3'b010, 1'b0, 2'b00};
    wv[1] = '{32'h200, 4'b0100, 32'h202, 3'b000, 1'b0, 2'b00};
    wv[2] = '{32'h200, 4'b0101, 32'h000, 3'b000, 1'b1, 2'b10};
    wv[3] = '{32'h300, 4'b1100, 32'h302, 3'b001, 1'b0, 2'b00};
    wv[4] = '{32'h300, 4'b0011, 32'h300, 3'b001, 1'b0, 2'b00};
    wv[5] = '{32'h401, 4'b0001, 32'h400, 3'b000, 1'b0, 2'b00};
    wv[6] = '{32'h400, 4'b0010, 32'h401, 3'b000, 1'b0, 2'b00};
    wv[7] = '{32'h403, 4'b1000, 32'h403, 3'b000, 1'b0, 2'b00};
    wv[8] = '{32'h500, 4'b0000, 32'h000, 3'b000, 1'b1, 2'b00};
    wv[9] = '{32'h500, 4'b0110, 32'h000, 3'b000, 1'b1, 2'b10};

    bus.s_awvalid = 0; bus.s_awaddr = '0; bus.s_wvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_bready = 0; bus.s_arvalid = 0; bus.s_araddr = '0; bus.s_rready = 0;
    bus2.s_awvalid = 0; bus2.s_awaddr = '0; bus2.s_wvalid = 0; bus2.s_wdata = '0;
    bus2.s_wstrb = '0; bus2.s_bready = 1; bus2.s_arvalid = 0; bus2.s_araddr = '0;
    bus2.s_rready = 1;

    repeat (3) @(negedge aclk);
    check("rst_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd0);
    check("rst_valids", {30'd0, bus.s_bvalid, bus.s_rvalid}, 32'd0);
    check("rst_resps", {28'd0, bus.s_bresp, bus.s_rresp}, 32'd0);
    check("rst_rdata", bus.s_rdata, 32'd0);
    check("rst_hsel_htrans", {29'd0, bus.ahb_m_hsel, bus.ahb_m_htrans}, 32'd0);
    check("rst_haddr", bus.ahb_m_haddr, 32'd0);
    check("rst_hwrite_hsize", {28'd0, bus.ahb_m_hwrite, bus.ahb_m_hsize}, 32'b0010);
    check("rst_hwdata", bus.ahb_m_hwdata, 32'd0);
    areset = 1'b0;

    // simultaneous AR and AW/W: write, read, write, four cycles apart each
    b0 = b_cnt; r0 = r_cnt;
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    fork
      begin
        do_write(32'h600, 32'hAAAA_0001, 4'b1111, w1);
        do_write(32'h604, 32'hAAAA_0002, 4'b1111, w2);
      end
      do_read(32'h610, rr);
    join
    repeat (6) @(negedge aclk);
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    check("arb_read_after_write", 32'(rr - w1), 32'd4);
    check("arb_write_after_read", 32'(w2 - rr), 32'd4);
    check("arb_b_count", 32'(b_cnt - b0), 32'd2);
    check("arb_r_count", 32'(r_cnt - r0), 32'd1);

    // strobe mapping table, latency, phase contents
    for (int i = 0; i < 10; i++) begin
      d   = 32'h1234_5678 + 32'(i) * 32'h0101_0101;
      ns0 = ns_cnt;
      do_write(wv[i].addr, d, wv[i].strb, acc);
      if (!wv[i].skip) begin
        check($sformatf("w%0d_addr_phase", i),
              {24'd0, bus.ahb_m_hsel, bus.ahb_m_htrans, bus.ahb_m_hburst, bus.ahb_m_hwrite, 1'b0},
              {24'd0, 1'b1, 2'b10, 3'b000, 1'b1, 1'b0});
        check($sformatf("w%0d_haddr", i), bus.ahb_m_haddr, wv[i].haddr);
        check($sformatf("w%0d_hsize", i), 32'(bus.ahb_m_hsize), 32'(wv[i].hsize));
        check($sformatf("w%0d_hprot", i), 32'(bus.ahb_m_hprot), 32'h3);
        @(negedge aclk);
        check($sformatf("w%0d_data_phase", i), {29'd0, bus.ahb_m_hsel, bus.ahb_m_htrans}, 32'd0);
        check($sformatf("w%0d_hwdata", i), bus.ahb_m_hwdata, d);
      end
      wait_resp(1'b1, (i == 0) ? 2 : 0, rsp, rd, at);
      check($sformatf("w%0d_bresp", i), 32'(rsp), 32'(wv[i].resp));
      check($sformatf("w%0d_latency", i), 32'(at - acc), wv[i].skip ? 32'd1 : 32'd3);
      check($sformatf("w%0d_nonseq", i), 32'(ns_cnt - ns0), wv[i].skip ? 32'd0 : 32'd1);
    end

    // read with 3 stalled address cycles
    cfg_stall = 3; cfg_rdata = 32'hCAFE_F00D; r0 = r_cnt; ns0 = ns_cnt;
    do_read(32'h0000_0010, acc);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_stall%0d_htrans", k), 32'(bus.ahb_m_htrans), 32'h2);
      check($sformatf("rd_stall%0d_hready", k), 32'(bus.ahb_m_hready), (k < 3) ? 32'd0 : 32'd1);
      check($sformatf("rd_stall%0d_haddr", k), bus.ahb_m_haddr, 32'h10);
      check($sformatf("rd_stall%0d_hwrite_hsize", k),
            {28'd0, bus.ahb_m_hwrite, bus.ahb_m_hsize}, 32'b0010);
      @(negedge aclk);
    end
    wait_resp(1'b0, 2, rsp, rd, at);
    check("rd_stall_rdata", rd, 32'hCAFE_F00D);
    check("rd_stall_rresp", 32'(rsp), 32'd0);
    check("rd_stall_latency", 32'(at - acc), 32'd6);
    check("rd_stall_rcount", 32'(r_cnt - r0), 32'd1);
    check("rd_stall_nonseq", 32'(ns_cnt - ns0), 32'd1);
    cfg_stall = 0;

    // unaligned read address is word aligned on AHB
    cfg_rdata = 32'h89AB_CDEF;
    do_read(32'h0000_0023, acc);
    check("rd2_haddr", bus.ahb_m_haddr, 32'h20);
    wait_resp(1'b0, 0, rsp, rd, at);
    check("rd2_rdata", rd, 32'h89AB_CDEF);
    check("rd2_latency", 32'(at - acc), 32'd3);

    // two RETRYs then OKAY
    cfg_retry = 2; ns0 = ns_cnt;
    do_write(32'h700, 32'h0BAD_F00D, 4'b1111, acc);
    wait_resp(1'b1, 0, rsp, rd, at);
    check("retry2_bresp", 32'(rsp), 32'd0);
    check("retry2_nonseq", 32'(ns_cnt - ns0), 32'd3);

    // RETRY forever: default RETRY_MAX=15 gives 16 transfers then SLVERR
    cfg_retry = 1000; ns0 = ns_cnt;
    do_write(32'h704, 32'h0000_0001, 4'b1111, acc);
    wait_resp(1'b1, 0, rsp, rd, at);
    check("retrymax_bresp", 32'(rsp), 32'd2);
    check("retrymax_nonseq", 32'(ns_cnt - ns0), 32'd16);
    cfg_retry = 0;

    // RETRY_MAX=2 instance, slave always RETRY
    ns0 = ns2;
    @(negedge aclk);
    bus2.s_awaddr = 32'h800; bus2.s_wdata = 32'h5555_AAAA; bus2.s_wstrb = 4'b1111;
    bus2.s_awvalid = 1'b1; bus2.s_wvalid = 1'b1;
    #1;
    check("r2_awready", 32'(bus2.s_awready), 32'd1);
    @(negedge aclk);
    bus2.s_awvalid = 1'b0; bus2.s_wvalid = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (bus2.s_bvalid) begin
          seen = 1;
          check("r2_bresp", 32'(bus2.s_bresp), 32'd2);
        end
        @(negedge aclk);
      end
      if (!seen) check("r2_bvalid_timeout", 32'd0, 32'd1);
    end
    check("r2_nonseq", 32'(ns2 - ns0), 32'd3);

    // reset during the data phase
    b0 = b_cnt; ns0 = ns_cnt;
    do_write(32'h900, 32'hDEAD_BEEF, 4'b1111, acc);
    @(negedge aclk);
    check("mid_in_data", 32'(bus.ahb_m_htrans), 32'd0);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("mid_rst_htrans_hsel", {29'd0, bus.ahb_m_hsel, bus.ahb_m_htrans}, 32'd0);
    check("mid_rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    check("mid_rst_haddr", bus.ahb_m_haddr, 32'd0);
    repeat (3) @(negedge aclk);
    check("mid_rst_no_bresp", 32'(b_cnt - b0), 32'd0);
    check("mid_rst_no_ahb", 32'(ns_cnt - ns0), 32'd1);
    do_write(32'h904, 32'h0000_1234, 4'b0011, acc);
    check("post_rst_haddr", bus.ahb_m_haddr, 32'h904);
    wait_resp(1'b1, 0, rsp, rd, at);
    check("post_rst_bresp", 32'(rsp), 32'd0);
    check("post_rst_latency", 32'(at - acc), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
